// File: rtl/apb_bridge_pkg.sv
// Shared types and default widths for the two-requester APB master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_ADDR_WD = 32;
    localparam int DEF_DATA_WD = 32;
    localparam int DEF_STRB_WD = DEF_DATA_WD / 8;
    localparam int DEF_PROT_WD = 3;
    localparam int DEF_TIMEOUT = 16;

    // Wait counter width; a disabled timeout still needs a one-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a pointer that moves past the last finished owner.
// Latency: grant is combinational; pointer updates one cycle after a completion.
// Backpressure: none; the caller decides when a grant is actually taken.
module rr_arb2 (
    input  logic       b_pclk,
    input  logic       b_prst,
    input  logic [1:0] req_vld,
    input  logic       done,
    input  logic       done_idx,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic ptr;

    // Pointer favours the requester that did not own the transfer that just ended.
    always_ff @(posedge b_pclk) begin
        if (b_prst) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~done_idx;
        end
    end

    // Pointer wins when it is requesting, otherwise the other side takes the slot.
    always_comb begin
        gnt_vld = |req_vld;
        gnt_idx = req_vld[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/apb_rr_master_arb.sv
// Round-robin arbitration of two valid/ready requesters onto one APB4 master port.
// Latency: accept T, SETUP T+1, ACCESS T+2.., response pulse one cycle after the last ACCESS.
// Backpressure: requests are only accepted in IDLE; b_pready stalls ACCESS until done or timeout.
module apb_rr_master_arb
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WD = DEF_ADDR_WD,
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int STRB_WD = DEF_STRB_WD,
    parameter int PROT_WD = DEF_PROT_WD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 b_pclk,
    input  logic                 b_prst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_write,
    input  logic [2*ADDR_WD-1:0] req_addr,
    input  logic [2*DATA_WD-1:0] req_wdata,
    input  logic [2*STRB_WD-1:0] req_strb,
    input  logic [2*PROT_WD-1:0] req_prot,
    output logic [1:0]           rsp_valid,
    output logic [DATA_WD-1:0]   rsp_rdata,
    output logic                 rsp_err,
    output logic                 b_psel,
    output logic                 b_penable,
    output logic                 b_pwrite,
    output logic [ADDR_WD-1:0]   b_paddr,
    output logic [DATA_WD-1:0]   b_pwdata,
    output logic [STRB_WD-1:0]   b_pstrb,
    output logic [PROT_WD-1:0]   b_pprot,
    input  logic [DATA_WD-1:0]   b_prdata,
    input  logic                 b_pready
);

    localparam int CNT_WD = cnt_width(TIMEOUT);

    apb_state_e         state;
    logic [CNT_WD-1:0]  acc_cnt;
    logic               own;
    logic               gnt_vld;
    logic               gnt_idx;
    logic               accept;
    logic               timeout_hit;
    logic               xfer_done;
    logic               sel_write;
    logic [ADDR_WD-1:0] sel_addr;
    logic [DATA_WD-1:0] sel_wdata;
    logic [STRB_WD-1:0] sel_strb;
    logic [PROT_WD-1:0] sel_prot;

    rr_arb2 u_arb (
        .b_pclk   (b_pclk),
        .b_prst   (b_prst),
        .req_vld  (req_valid),
        .done     (xfer_done),
        .done_idx (own),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    // Accept decision, abort detection and the granted requester's fields.
    always_comb begin
        accept      = (state == IDLE) && gnt_vld && !b_prst;
        req_ready   = 2'b00;
        if (accept) begin
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        end
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = (acc_cnt == CNT_WD'(TIMEOUT - 1));
        end
        xfer_done = (state == ACCESS) && (b_pready || timeout_hit);
        sel_write = req_write[gnt_idx];
        sel_addr  = gnt_idx ? req_addr[2*ADDR_WD-1:ADDR_WD]  : req_addr[ADDR_WD-1:0];
        sel_wdata = gnt_idx ? req_wdata[2*DATA_WD-1:DATA_WD] : req_wdata[DATA_WD-1:0];
        sel_strb  = gnt_idx ? req_strb[2*STRB_WD-1:STRB_WD]  : req_strb[STRB_WD-1:0];
        sel_prot  = gnt_idx ? req_prot[2*PROT_WD-1:PROT_WD]  : req_prot[PROT_WD-1:0];
    end

    // APB sequencer: registered bus outputs, wait counter and one-cycle response pulse.
    always_ff @(posedge b_pclk) begin
        if (b_prst) begin
            state     <= IDLE;
            own       <= 1'b0;
            acc_cnt   <= '0;
            b_psel    <= 1'b0;
            b_penable <= 1'b0;
            b_pwrite  <= 1'b0;
            b_paddr   <= '0;
            b_pwdata  <= '0;
            b_pstrb   <= '0;
            b_pprot   <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SETUP;
                        own      <= gnt_idx;
                        acc_cnt  <= '0;
                        b_psel   <= 1'b1;
                        b_pwrite <= sel_write;
                        b_paddr  <= sel_addr;
                        b_pwdata <= sel_wdata;
                        b_pstrb  <= sel_write ? sel_strb : '0;
                        b_pprot  <= sel_prot;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    b_penable <= 1'b1;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        state          <= IDLE;
                        b_psel         <= 1'b0;
                        b_penable      <= 1'b0;
                        rsp_valid[own] <= 1'b1;
                        rsp_err        <= !b_pready;
                        rsp_rdata      <= (b_pready && !b_pwrite) ? b_prdata : '0;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed bench for apb_rr_master_arb with a transaction-level reference model.
// Latency: n/a.
// Backpressure: the bench slave inserts wait states or holds b_pready low on demand.
module tb_apb_rr_master_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int PW = 3;
    localparam int TO = 16;

    logic          b_pclk;
    logic          b_prst;
    logic [1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_strb;
    logic [2*PW-1:0] req_prot;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          b_psel, b_penable, b_pwrite, b_pready;
    logic [AW-1:0] b_paddr;
    logic [DW-1:0] b_pwdata, b_prdata;
    logic [SW-1:0] b_pstrb;
    logic [PW-1:0] b_pprot;

    int n_cmp = 0;
    int n_err = 0;

    apb_rr_master_arb #(.ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW), .TIMEOUT(TO)) dut (
        .b_pclk(b_pclk), .b_prst(b_prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
        .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pstrb(b_pstrb), .b_pprot(b_pprot),
        .b_prdata(b_prdata), .b_pready(b_pready)
    );

    initial begin
        b_pclk = 1'b0;
        forever #5 b_pclk = ~b_pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // ---------------- bench APB slave ----------------
    logic [31:0] mem [0:255];
    int          wait_n = 0;
    bit          stuck  = 0;
    int          acc_k  = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        b_pready = 1'b0;
        b_prdata = '0;
        forever begin
            @(posedge b_pclk);
            #1;
            if (b_psel && b_penable) begin
                b_pready = !stuck && (acc_k >= wait_n);
                b_prdata = mem[b_paddr[9:2]];
                if (b_pready && b_pwrite) mem[b_paddr[9:2]] = b_pwdata;
                acc_k++;
            end else begin
                acc_k    = 0;
                b_pready = 1'b0;
                b_prdata = '0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          chk_en = 0;
    bit          m_busy = 0;
    int          m_age  = 0;
    logic        m_own  = 0;
    logic        m_ptr  = 0;
    logic        m_wr   = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rd = 0;
    logic [3:0]  m_strb = 0;
    logic [2:0]  m_prot = 0;
    logic [1:0]  m_rv   = 0;
    logic        m_re   = 0;
    logic [1:0]  e_rdy;
    logic        eg;
    int          gi;

    always @(negedge b_pclk) begin
        e_rdy = 2'b00;
        eg    = 1'b0;
        if (!m_busy && !b_prst && (req_valid != 2'b00)) begin
            eg    = req_valid[m_ptr] ? m_ptr : !m_ptr;
            e_rdy = eg ? 2'b10 : 2'b01;
        end
        if (chk_en) begin
            chk("req_ready", req_ready, e_rdy);
            chk("b_psel", b_psel, m_busy);
            chk("b_penable", b_penable, m_busy && (m_age >= 2));
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_err", rsp_err, m_re);
            chk("rsp_rdata", rsp_rdata, m_rd);
            if (m_busy) begin
                chk("b_pwrite", b_pwrite, m_wr);
                chk("b_paddr", b_paddr, m_addr);
                chk("b_pwdata", b_pwdata, m_wdata);
                chk("b_pstrb", b_pstrb, m_wr ? m_strb : 4'h0);
                chk("b_pprot", b_pprot, m_prot);
            end
        end
        if (b_prst) begin
            chk_en = 1;
            m_busy = 0;
            m_ptr  = 0;
            m_rv   = 0;
            m_re   = 0;
            m_rd   = 0;
        end else begin
            m_rv = 0;
            m_re = 0;
            m_rd = 0;
            if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    gi      = int'(eg);
                    m_own   = eg;
                    m_busy  = 1;
                    m_age   = 1;
                    m_wr    = req_write[gi];
                    m_addr  = req_addr[gi*AW +: AW];
                    m_wdata = req_wdata[gi*DW +: DW];
                    m_strb  = req_strb[gi*SW +: SW];
                    m_prot  = req_prot[gi*PW +: PW];
                end
            end else if (m_age >= 2 && (b_pready || (TO != 0 && (m_age - 2) == TO - 1))) begin
                m_busy      = 0;
                m_rv[m_own] = 1'b1;
                m_re        = !b_pready;
                m_rd        = (b_pready && !m_wr) ? b_prdata : 32'h0;
                m_ptr       = !m_own;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge b_pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_prot[i*PW +: PW]  = p;
        req_valid[i]          = 1'b1;
    endtask

    // Runs from +1 of a cycle until the response cycle, returning at +3 of it.
    task automatic run_to_rsp(output int psel_n, output int acc_n, output int addr_chg,
                              output logic [1:0] rv, output logic [31:0] rd, output logic re);
        logic [31:0] a0;
        bit          got;
        psel_n = 0; acc_n = 0; addr_chg = 0; rv = 0; rd = 0; re = 0; got = 0; a0 = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            #2;
            if (rsp_valid != 2'b00) begin
                got = 1;
                rv  = rsp_valid;
                rd  = rsp_rdata;
                re  = rsp_err;
            end else begin
                if (b_psel) begin
                    if (psel_n == 0) a0 = b_paddr;
                    else if (b_paddr !== a0) addr_chg++;
                    psel_n++;
                end
                if (b_psel && b_penable) acc_n++;
                tick();
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_wait_bound: got no response in 100 cycles required a response");
        end
    endtask

    int          psel_n, acc_n, addr_chg, ng, c0, c1, both, sbad, rv_bad;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        re;
    logic [3:0]  ord;
    bit          d0, d1;

    initial begin
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        b_prst    = 1'b1;

        // 1: reset held three edges with both requesters asking
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("t1_req_ready", req_ready, 2'b00);
            chk("t1_psel", b_psel, 1'b0);
            chk("t1_penable", b_penable, 1'b0);
            chk("t1_rsp_valid", rsp_valid, 2'b00);
        end
        b_prst    = 1'b0;
        req_valid = 2'b00;
        tick();

        // 2: single zero-wait write from requester 0
        wait_n = 0;
        stuck  = 0;
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'h2);
        #2 chk("t2_ready_T", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #2;
        chk("t2_psel_T1", b_psel, 1'b1);
        chk("t2_penable_T1", b_penable, 1'b0);
        chk("t2_paddr", b_paddr, 32'h10);
        chk("t2_pstrb", b_pstrb, 4'hF);
        tick();
        #2;
        chk("t2_penable_T2", b_penable, 1'b1);
        tick();
        #2;
        chk("t2_rsp_valid_T3", rsp_valid, 2'b01);
        chk("t2_psel_T3", b_psel, 1'b0);
        tick();

        // 3: read back from requester 1 with two wait states
        wait_n = 2;
        set_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 3'h0);
        #2 chk("t3_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t3_psel_cycles", psel_n, 4);
        chk("t3_addr_changes", addr_chg, 0);
        chk("t3_rsp_valid", rv, 2'b10);
        chk("t3_rdata", rd, 32'hDEAD_BEEF);
        chk("t3_err", re, 1'b0);
        tick();

        // 4: both requesters stream two reads each
        wait_n = 0;
        set_req(0, 1'b0, 32'h20, 32'h1111_1111, 4'hF, 3'h1);
        set_req(1, 1'b0, 32'h30, 32'h2222_2222, 4'hF, 3'h5);
        ng = 0; c0 = 0; c1 = 0; both = 0; sbad = 0; ord = 4'h0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            #2;
            if (req_ready == 2'b11) both++;
            if (b_psel && b_pstrb != 4'h0) sbad++;
            d0 = 0;
            d1 = 0;
            if (req_ready[0]) begin
                ord = {ord[2:0], 1'b0}; ng++; c0++; d0 = (c0 == 2);
            end else if (req_ready[1]) begin
                ord = {ord[2:0], 1'b1}; ng++; c1++; d1 = (c1 == 2);
            end
            tick();
            if (d0) req_valid[0] = 1'b0;
            if (d1) req_valid[1] = 1'b0;
        end
        chk("t4_grants", ng, 4);
        chk("t4_order", ord, 4'b0101);
        chk("t4_both_ready", both, 0);
        chk("t4_pstrb_nonzero", sbad, 0);
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t4_last_rsp", rv, 2'b10);
        chk("t4_last_rdata", rd, 32'hA500_000C);
        tick();

        // 5: slave never ready -> abort after the full wait budget
        stuck = 1;
        set_req(0, 1'b1, 32'h40, 32'h5555_AAAA, 4'h3, 3'h0);
        #2 chk("t5_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t5_access_cycles", acc_n, TO);
        chk("t5_rsp_valid", rv, 2'b01);
        chk("t5_err", re, 1'b1);
        chk("t5_rdata", rd, 32'h0);
        stuck = 0;
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'h0);
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'h0);
        #1 chk("t5_next_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t5_next_rsp", rv, 2'b10);
        chk("t5_next_rdata", rd, 32'hDEAD_BEEF);
        tick();

        // 6: reset during ACCESS after the pointer has moved to requester 1
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'h0);
        #2 chk("t6_ready_a", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t6_rsp_a", rv, 2'b01);
        tick();
        wait_n = 5;
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'h0);
        #2 chk("t6_ready_b", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        #2 chk("t6_in_access", b_penable, 1'b1);
        b_prst = 1'b1;
        tick();
        b_prst = 1'b0;
        #2;
        chk("t6_psel_after_rst", b_psel, 1'b0);
        chk("t6_penable_after_rst", b_penable, 1'b0);
        rv_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid != 2'b00) rv_bad++;
            tick();
            #2;
        end
        chk("t6_no_rsp", rv_bad, 0);
        wait_n = 0;
        set_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'h0);
        set_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'h0);
        #1 chk("t6_ptr_reset_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        run_to_rsp(psel_n, acc_n, addr_chg, rv, rd, re);
        chk("t6_final_rsp", rv, 2'b01);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
